// File: rtl/reaction_pkg.sv
// Shared types and constants for the multi-player reaction arena.
package reaction_pkg;

  // Round state machine encoding.
  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_ARMED,
    S_DONE,
    S_FOUL
  } arena_state_t;

  // LFSR seed and Fibonacci tap mask for x^16 + x^14 + x^13 + x^11 + 1.
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // Number of clock cycles in one millisecond tick.
  function automatic int ms_per_tick(input int clk_hz);
    return clk_hz / 1000;
  endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Fibonacci LFSR, shifting left with feedback into bit 0.
module lfsr16
  import reaction_pkg::*;
(
  input  logic        clk,
  input  logic        clear,
  output logic [15:0] q
);

  // Advance one step per cycle; clear reloads the seed.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (clear) q <= LFSR_SEED;
    else       q <= {q[14:0], ^(q & LFSR_TAPS)};
  end

endmodule

// File: rtl/reaction_arena.sv
// N-player reaction timer: random arming delay, millisecond timing,
// per-player false-start detection, registered result/winner/foul outputs.
module reaction_arena
  import reaction_pkg::*;
#(
  parameter int CLK_HZ        = 50_000_000,
  parameter int N_PLAYERS     = 2,
  parameter int MIN_DELAY_MS  = 2000,
  parameter int SPAN_LOG2     = 12,
  parameter int MAX_RESULT_MS = 9999,
  parameter int TIME_W        = 14
) (
  input  logic                 clk_50M,
  input  logic                 clear,
  input  logic                 start,
  input  logic [N_PLAYERS-1:0] stop,
  output logic                 LED,
  output logic [TIME_W-1:0]    result_ms,
  output logic [N_PLAYERS-1:0] winner,
  output logic [N_PLAYERS-1:0] foul,
  output logic                 done,
  output logic                 busy
);

  localparam int TICK_CYCLES = ms_per_tick(CLK_HZ);
  localparam int PRE_W       = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [PRE_W-1:0]  PRE_LAST   = PRE_W'(TICK_CYCLES - 1);
  localparam logic [TIME_W-1:0] MIN_DELAY  = TIME_W'(MIN_DELAY_MS);
  localparam logic [TIME_W-1:0] MAX_RESULT = TIME_W'(MAX_RESULT_MS);

  // Bit 0 carries start, bits N_PLAYERS:1 carry the stop buttons.
  logic [N_PLAYERS:0] in_meta, in_sync, in_prev, in_edge;
  logic               start_edge;
  logic [N_PLAYERS-1:0] stop_edge;

  logic [15:0]       lfsr_q;
  logic              lfsr_unused;
  arena_state_t      state;
  logic [PRE_W-1:0]  pre_cnt;
  logic              tick;
  logic [TIME_W-1:0] wait_ms, delay_ms;
  logic [TIME_W-1:0] wait_next, result_next;

  lfsr16 u_lfsr (
    .clk   (clk_50M),
    .clear (clear),
    .q     (lfsr_q)
  );

  // Only the low SPAN_LOG2 bits feed the delay; the rest are deliberately unused.
  assign lfsr_unused = ^lfsr_q;

  // Two-stage synchroniser followed by a registered rising-edge pulse.
  always_ff @(posedge clk_50M) begin
    if (clear) begin
      in_meta <= '0;
      in_sync <= '0;
      in_prev <= '0;
      in_edge <= '0;
    end else begin
      in_meta <= {stop, start};
      in_sync <= in_meta;
      in_prev <= in_sync;
      in_edge <= in_sync & ~in_prev;
    end
  end

  assign start_edge  = in_edge[0];
  assign stop_edge   = in_edge[N_PLAYERS:1];
  assign tick        = (pre_cnt == PRE_LAST);
  assign wait_next   = wait_ms + TIME_W'(1);
  assign result_next = result_ms + TIME_W'(1);

  // Round FSM with millisecond prescaler, counters and registered outputs.
  always_ff @(posedge clk_50M) begin
    if (clear) begin
      state     <= S_IDLE;
      pre_cnt   <= '0;
      wait_ms   <= '0;
      delay_ms  <= '0;
      result_ms <= '0;
      winner    <= '0;
      foul      <= '0;
      LED       <= 1'b0;
      done      <= 1'b0;
      busy      <= 1'b0;
    end else begin
      // NOTE: the last non-blocking assignment in a block wins, so the state-entry zeroing below overrides this free-run step.
      pre_cnt <= tick ? '0 : pre_cnt + PRE_W'(1);
      unique case (state)
        S_IDLE, S_DONE, S_FOUL: begin
          if (start_edge) begin
            delay_ms  <= MIN_DELAY + TIME_W'(lfsr_q[SPAN_LOG2-1:0]);
            wait_ms   <= '0;
            result_ms <= '0;
            winner    <= '0;
            foul      <= '0;
            done      <= 1'b0;
            busy      <= 1'b1;
            pre_cnt   <= '0;
            state     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (|stop_edge) begin
            // A press before the lamp is a foul, even on the arming tick.
            foul    <= stop_edge;
            LED     <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b1;
            pre_cnt <= '0;
            state   <= S_FOUL;
          end else if (tick) begin
            wait_ms <= wait_next;
            if (wait_next == delay_ms) begin
              LED     <= 1'b1;
              pre_cnt <= '0;
              state   <= S_ARMED;
            end
          end
        end
        S_ARMED: begin
          if (|stop_edge) begin
            // A press on the saturating tick still wins, reporting the ceiling.
            if (tick && result_next == MAX_RESULT) result_ms <= MAX_RESULT;
            winner  <= stop_edge;
            LED     <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b1;
            pre_cnt <= '0;
            state   <= S_DONE;
          end else if (tick) begin
            result_ms <= result_next;
            if (result_next == MAX_RESULT) begin
              winner  <= '0;
              LED     <= 1'b0;
              busy    <= 1'b0;
              done    <= 1'b1;
              pre_cnt <= '0;
              state   <= S_DONE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reaction_arena.sv
// Scoreboard bench for reaction_arena at 10 cycles per millisecond.
module tb_reaction_arena;

  localparam int CLK_HZ = 10_000;
  localparam int NP     = 2;
  localparam int MIN_D  = 20;
  localparam int SPAN   = 4;
  localparam int MAXR   = 50;
  localparam int TW     = 8;

  logic          clk = 1'b0;
  logic          clear = 1'b1;
  logic          start = 1'b0;
  logic [NP-1:0] stop = '0;
  logic          led;
  logic [TW-1:0] result_ms;
  logic [NP-1:0] winner, foul;
  logic          done, busy;

  int checks = 0;
  int errors = 0;
  int d_first = 0;

  typedef struct {
    string         name;
    logic [NP-1:0] winner;
    logic [NP-1:0] foul;
    logic [TW-1:0] result;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  reaction_arena #(
    .CLK_HZ(CLK_HZ), .N_PLAYERS(NP), .MIN_DELAY_MS(MIN_D),
    .SPAN_LOG2(SPAN), .MAX_RESULT_MS(MAXR), .TIME_W(TW)
  ) dut (
    .clk_50M   (clk),
    .clear     (clear),
    .start     (start),
    .stop      (stop),
    .LED       (led),
    .result_ms (result_ms),
    .winner    (winner),
    .foul      (foul),
    .done      (done),
    .busy      (busy)
  );

  // Reference LFSR: x^16 + x^14 + x^13 + x^11 + 1, seed ACE1, reset by clear.
  logic [15:0] m_lfsr;
  always @(posedge clk) begin
    if (clear) m_lfsr <= 16'hACE1;
    else       m_lfsr <= {m_lfsr[14:0], m_lfsr[16-1] ^ m_lfsr[14-1] ^ m_lfsr[13-1] ^ m_lfsr[11-1]};
  end

  function automatic exp_t mk_exp(input string nm, input logic [NP-1:0] w,
                                  input logic [NP-1:0] f, input logic [TW-1:0] r);
    exp_t e;
    e.name = nm; e.winner = w; e.foul = f; e.result = r;
    return e;
  endfunction

  // Scoreboard consumer: each rising done pops one expected round outcome.
  bit done_prev = 1'b0;
  always @(negedge clk) begin : monitor
    exp_t e;
    if (done === 1'b1 && !done_prev) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_done: got winner=%b foul=%b result=%0d, expected no round end", winner, foul, result_ms);
      end else begin
        e = sb.pop_front();
        checks++;
        if (winner !== e.winner) begin
          errors++; $display("FAIL %s_winner: got %b expected %b", e.name, winner, e.winner);
        end
        checks++;
        if (foul !== e.foul) begin
          errors++; $display("FAIL %s_foul: got %b expected %b", e.name, foul, e.foul);
        end
        checks++;
        if (result_ms !== e.result) begin
          errors++; $display("FAIL %s_result: got %0d expected %0d", e.name, result_ms, e.result);
        end
        checks++;
        if (led !== 1'b0 || busy !== 1'b0) begin
          errors++; $display("FAIL %s_idle_flags: got led=%b busy=%b expected 0 0", e.name, led, busy);
        end
      end
    end
    done_prev = (done === 1'b1);
  end

  // Pulse start and return the delay the DUT will latch from the model LFSR.
  task automatic press_start(output int d);
    @(negedge clk) start = 1'b1;
    repeat (3) @(posedge clk);
    #1 d = MIN_D + int'(m_lfsr[SPAN-1:0]);
    @(negedge clk) start = 1'b0;
  endtask

  // Count cycles until LED rises; optionally re-press start at cycle restart_at.
  task automatic wait_led(input int restart_at, output int n, output bit ok);
    n = 0; ok = 1'b0;
    while (n < 2000) begin
      @(negedge clk);
      n++;
      if (n == restart_at)     start = 1'b1;
      if (n == restart_at + 4) start = 1'b0;
      if (led === 1'b1) begin ok = 1'b1; break; end
    end
    start = 1'b0;
  endtask

  task automatic wait_done(output int n, output bit ok);
    n = 0; ok = 1'b0;
    while (n < 2000) begin
      @(negedge clk);
      n++;
      if (done === 1'b1) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    clear = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (led !== 1'b0)    begin errors++; $display("FAIL reset_led: got %b expected 0", led); end
    checks++; if (result_ms !== 0) begin errors++; $display("FAIL reset_result: got %0d expected 0", result_ms); end
    checks++; if (winner !== 0)    begin errors++; $display("FAIL reset_winner: got %b expected 00", winner); end
    checks++; if (foul !== 0)      begin errors++; $display("FAIL reset_foul: got %b expected 00", foul); end
    checks++; if (done !== 1'b0)   begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (busy !== 1'b0)   begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    clear = 1'b0;
  endtask

  task automatic test_normal_round();
    int d, n; bit ok;
    press_start(d);
    d_first = d;
    wait_led(0, n, ok);
    checks++;
    if (!ok || n != 10 * d + 1) begin
      errors++; $display("FAIL normal_arm_delay: got %0d cycles expected %0d", n - 1, 10 * d);
    end
    repeat (119) @(negedge clk);
    stop = 2'b01;
    sb.push_back(mk_exp("normal", 2'b01, 2'b00, 8'd12));
    wait_done(n, ok);
    checks++; if (!ok) begin errors++; $display("FAIL normal_done: got timeout expected done"); end
    // A later press in DONE must not disturb the held outcome.
    stop = 2'b00;
    repeat (5) @(negedge clk);
    stop = 2'b10;
    repeat (8) @(negedge clk);
    checks++;
    if (winner !== 2'b01 || result_ms !== 8'd12 || done !== 1'b1) begin
      errors++; $display("FAIL stop_in_done: got winner=%b result=%0d done=%b expected 01 12 1", winner, result_ms, done);
    end
    stop = 2'b00;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_false_start();
    int d, n; bit ok, led_hi;
    press_start(d);
    led_hi = 1'b0;
    repeat (46) begin
      @(negedge clk);
      if (led === 1'b1) led_hi = 1'b1;
    end
    stop = 2'b10;
    sb.push_back(mk_exp("false_start", 2'b00, 2'b10, 8'd0));
    wait_done(n, ok);
    checks++; if (!ok) begin errors++; $display("FAIL false_start_done: got timeout expected done"); end
    checks++; if (led_hi) begin errors++; $display("FAIL false_start_led: got LED high expected never"); end
    stop = 2'b00;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_tie();
    int d, n; bit ok;
    press_start(d);
    wait_led(0, n, ok);
    checks++;
    if (!ok || n != 10 * d + 1) begin
      errors++; $display("FAIL tie_arm_delay: got %0d cycles expected %0d", n - 1, 10 * d);
    end
    repeat (75) @(negedge clk);
    stop = 2'b11;
    sb.push_back(mk_exp("tie", 2'b11, 2'b00, 8'd7));
    wait_done(n, ok);
    checks++; if (!ok) begin errors++; $display("FAIL tie_done: got timeout expected done"); end
    stop = 2'b00;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_timeout();
    int d, n; bit ok;
    press_start(d);
    wait_led(0, n, ok);
    checks++;
    if (!ok || n != 10 * d + 1) begin
      errors++; $display("FAIL timeout_arm_delay: got %0d cycles expected %0d", n - 1, 10 * d);
    end
    sb.push_back(mk_exp("timeout", 2'b00, 2'b00, 8'(MAXR)));
    wait_done(n, ok);
    checks++;
    if (!ok || n != 10 * MAXR) begin
      errors++; $display("FAIL timeout_latency: got %0d cycles expected %0d", n, 10 * MAXR);
    end
    repeat (5) @(negedge clk);
  endtask

  task automatic test_start_ignored_in_wait();
    int d, n; bit ok;
    press_start(d);
    wait_led(30, n, ok);
    checks++;
    if (!ok || n != 10 * d + 1) begin
      errors++; $display("FAIL restart_in_wait: got %0d cycles expected %0d", n - 1, 10 * d);
    end
    repeat (9) @(negedge clk);
    stop = 2'b01;
    sb.push_back(mk_exp("restart_ignored", 2'b01, 2'b00, 8'd1));
    wait_done(n, ok);
    checks++; if (!ok) begin errors++; $display("FAIL restart_done: got timeout expected done"); end
    stop = 2'b00;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_clear_mid_armed();
    int d, n; bit ok;
    press_start(d);
    wait_led(0, n, ok);
    repeat (30) @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    checks++;
    if (led !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || winner !== 0 || foul !== 0 || result_ms !== 0) begin
      errors++;
      $display("FAIL clear_armed: got led=%b busy=%b done=%b winner=%b foul=%b result=%0d expected all 0",
               led, busy, done, winner, foul, result_ms);
    end
    clear = 1'b0;
    press_start(d);
    checks++;
    if (d != d_first) begin
      errors++; $display("FAIL clear_seed_delay: got %0d ms expected %0d ms", d, d_first);
    end
    wait_led(0, n, ok);
    checks++;
    if (!ok || n != 10 * d + 1) begin
      errors++; $display("FAIL clear_arm_delay: got %0d cycles expected %0d", n - 1, 10 * d);
    end
    repeat (4) @(negedge clk);
    stop = 2'b10;
    sb.push_back(mk_exp("after_clear", 2'b10, 2'b00, 8'd0));
    wait_done(n, ok);
    checks++; if (!ok) begin errors++; $display("FAIL after_clear_done: got timeout expected done"); end
    stop = 2'b00;
    repeat (5) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_normal_round();
    test_false_start();
    test_tie();
    test_timeout();
    test_start_ignored_in_wait();
    test_clear_mid_armed();
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/reaction_arena.md
# reaction_arena

`reaction_arena` is the parametrised successor to the single-player reaction-time main logic. It serves N players and draws a pseudo-random arming delay from an LFSR. It measures reaction time in milliseconds rather than raw cycles, and detects false starts per player. It sits between the debounced panel buttons and the seven-segment/LED display logic, and produces registered result, winner and foul vectors for the display encoder.

## Interface
- `CLK_HZ`, default 50_000_000: clock frequency; `CLK_HZ % 1000 == 0` is required.
- `N_PLAYERS`, default 2: number of stop buttons, 1..8.
- `MIN_DELAY_MS`, default 2000: minimum arming delay.
- `SPAN_LOG2`, default 12: delay span is 2^SPAN_LOG2 ms, giving 2000..6095 ms.
- `MAX_RESULT_MS`, default 9999: result saturation value and timeout.
- `TIME_W`, default 14: width of ms counters; it must hold `MIN_DELAY_MS + 2^SPAN_LOG2 - 1` and `MAX_RESULT_MS`.
- `clk_50M` in, 1: the single clock, frequency `CLK_HZ`.
- `clear` in, 1: synchronous, active-high reset.
- `start` in, 1: round-start button, asynchronous level.
- `stop` in, N_PLAYERS: per-player stop buttons, asynchronous levels.
- `LED` out, 1: go lamp; high only in ARMED.
- `result_ms` out, TIME_W: reaction time of the winning press.
- `winner` out, N_PLAYERS: players whose press ended the round; multi-hot on a tie.
- `foul` out, N_PLAYERS: players who pressed during WAIT.
- `done` out, 1: high in DONE or FOUL.
- `busy` out, 1: high in WAIT or ARMED.

## Operation
- `start` and each `stop` bit pass through a 2-FF synchroniser and then a registered rising-edge detector. Levels are ignored; only rising edges act.
- A free-running 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1) advances every cycle in every state. It is reset to the seed by `clear`.
- The ms prescaler counts 0..CLK_HZ/1000-1. It pulses `tick` on the terminal count and is zeroed whenever a state is entered.
- State machine: IDLE, WAIT, ARMED, DONE, FOUL. Reset state is IDLE.
- IDLE/DONE/FOUL + start edge:
  - latch `delay_ms = MIN_DELAY_MS + lfsr[SPAN_LOG2-1:0]`;
  - zero `wait_ms`, `result_ms`, `winner` and `foul`;
  - go to WAIT.
- WAIT:
  - `wait_ms` increments on `tick`.
  - When the incremented value equals `delay_ms`, go to ARMED and set `LED`=1.
  - Any stop edge goes to FOUL with `foul` = that stop-edge vector (all simultaneous presses flagged) and `LED`=0.
  - A stop edge and the arming tick in the same cycle: the stop wins, giving FOUL.
- ARMED:
  - `result_ms` increments on `tick`.
  - Any stop edge goes to DONE with `winner` = that stop-edge vector, `result_ms` frozen, and `LED`=0.
  - If `result_ms` reaches `MAX_RESULT_MS`, go to DONE with `winner`=0 (timeout) and `result_ms`=MAX_RESULT_MS.
  - A stop edge in the same cycle as the saturating tick counts as a win; `result_ms` holds MAX_RESULT_MS.
- Start edges in WAIT or ARMED are ignored. Stop edges in IDLE, DONE or FOUL are ignored.
- DONE and FOUL hold all outputs until a start edge or `clear`.
- `clear` has priority over every event. It resets the FSM, counters, synchronisers, edge registers and LFSR.

## Timing
- Reset values: `LED`=0, `result_ms`=0, `winner`=0, `foul`=0, `done`=0, `busy`=0, state IDLE.
- Pin-to-edge latency is 3 cycles (2 sync + 1 edge register). Outputs are registered and update 1 cycle after the edge pulse, so pin to `winner`/`foul`/`done` is 4 cycles.
- `LED` rises in the cycle after the tick on which `wait_ms` reaches `delay_ms`. It falls in the same cycle that `done` rises.
- `result_ms` resolution is 1 ms. The first tick after arming comes a full CLK_HZ/1000 cycles after ARMED entry.
- `clear` takes effect on the next clock edge. All outputs are at reset values in the cycle after `clear` is sampled high, including mid-round.

## Structure
- Package `reaction_pkg` holds:
  - the state enum `arena_state_t`;
  - `LFSR_SEED` and the tap mask;
  - a `ms_per_tick` helper constant function.
- Sub-module `lfsr16`: free-running, synchronous reset to seed, with 16-bit `q` output. Everything else stays in `reaction_arena`.

## Test plan
Bench parameters: `CLK_HZ`=10_000 (10 cycles/ms), `N_PLAYERS`=2, `MIN_DELAY_MS`=20, `SPAN_LOG2`=4, `MAX_RESULT_MS`=50, `TIME_W`=8.

1. Normal round:
   - stimulus: reset, start pulse; compute `delay_ms` from a model LFSR; press stop[0] 120 cycles after `LED` rises;
   - response: `winner`=2'b01, `result_ms`=12, `done`=1, `LED`=0.
2. False start: start, then stop[1] 50 cycles later (still in WAIT) -> FOUL, `foul`=2'b10, `LED` never rises, `winner`=0.
3. Tie: both stop bits rise in the same cycle while ARMED -> `winner`=2'b11, identical `result_ms`.
4. Timeout: no stop after arming -> after 500 cycles `done`=1, `winner`=0, `result_ms`=50.
5. Clear mid-ARMED: assert `clear` 1 cycle -> next cycle `LED`=0, `busy`=0, all outputs 0; a later start produces the seed-derived first delay again.
6. Ignored events:
   - start edge during WAIT does not re-latch `delay_ms`;
   - stop edge in DONE leaves `winner` and `result_ms` unchanged.
